// File: rtl/pcs_10g_pkg.sv
// Shared 10GBASE-R PCS definitions: sync header codes and the block-lock state encoding,
// used by the block synchroniser, loopback and decoder.
package pcs_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_WAIT = 2'd2,
    LOCKED    = 2'd3
  } bs_state_e;

endpackage : pcs_10g_pkg

// File: rtl/pcs_10g_block_sync.sv
// 10GBASE-R receive block synchroniser: hunts for 66b alignment by slipping the gearbox
// until a full window of valid sync headers is seen, then monitors for loss of lock.
module pcs_10g_block_sync
  import pcs_10g_pkg::*;
#(
  parameter int HEAD_W      = 2,
  parameter int SH_GOOD_N   = 64,
  parameter int SH_BAD_N    = 16,
  parameter int SLIP_WAIT_N = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_ok_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  output logic              slip_o,
  output logic              block_lock_o
);

  localparam int CNT_W = $clog2(SH_GOOD_N + 1);
  localparam int INV_W = $clog2(SH_BAD_N + 1);

  localparam logic [CNT_W-1:0] GOOD_MAX = CNT_W'(SH_GOOD_N);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(SLIP_WAIT_N);
  localparam logic [INV_W-1:0] BAD_MAX  = INV_W'(SH_BAD_N);

  bs_state_e        state_q, state_d;
  logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0] sh_invld_cnt_q, sh_invld_cnt_d;
  logic             slip_q, slip_d;
  logic             lock_q, lock_d;

  logic             sh_ok;
  logic [CNT_W-1:0] sh_cnt_inc;
  logic [INV_W-1:0] sh_invld_inc;

  assign sh_ok        = (head_i == HEAD_W'(SYNC_DATA)) || (head_i == HEAD_W'(SYNC_CTRL));
  assign sh_cnt_inc   = sh_cnt_q + CNT_W'(1);
  assign sh_invld_inc = sh_invld_cnt_q + (sh_ok ? INV_W'(0) : INV_W'(1));

  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    slip_d         = 1'b0;
    lock_d         = lock_q;

    if (!signal_ok_i) begin
      state_d        = LOCK_INIT;
      sh_cnt_d       = '0;
      sh_invld_cnt_d = '0;
      lock_d         = 1'b0;
    end else begin
      case (state_q)
        LOCK_INIT: begin
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
          lock_d         = 1'b0;
          state_d        = TEST_SH;
        end

        TEST_SH: begin
          if (valid_i) begin
            if (!sh_ok) begin
              slip_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
              state_d        = SLIP_WAIT;
            end else if (sh_cnt_inc == GOOD_MAX) begin
              lock_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
              state_d        = LOCKED;
            end else begin
              sh_cnt_d = sh_cnt_inc;
            end
          end
        end

        // sh_cnt doubles as the discard counter while the gearbox settles after a slip
        SLIP_WAIT: begin
          if (valid_i) begin
            if (sh_cnt_inc >= WAIT_MAX) begin
              sh_cnt_d = '0;
              state_d  = TEST_SH;
            end else begin
              sh_cnt_d = sh_cnt_inc;
            end
          end
        end

        LOCKED: begin
          if (valid_i) begin
            if (sh_invld_inc == BAD_MAX) begin
              lock_d         = 1'b0;
              slip_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
              state_d        = SLIP_WAIT;
            end else if (sh_cnt_inc == GOOD_MAX) begin
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d       = sh_cnt_inc;
              sh_invld_cnt_d = sh_invld_inc;
            end
          end
        end

        default: begin
          state_d        = LOCK_INIT;
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
          lock_d         = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= LOCK_INIT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      slip_q         <= 1'b0;
      lock_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      slip_q         <= slip_d;
      lock_q         <= lock_d;
    end
  end

  assign slip_o       = slip_q;
  assign block_lock_o = lock_q;

endmodule : pcs_10g_block_sync

// File: tb/tb_pcs_10g_block_sync.sv
// Directed vector bench for pcs_10g_block_sync: per-cycle {inputs, expected outputs}
// records plus hand-written reset sequences.
module tb_pcs_10g_block_sync;

  logic       clk;
  logic       nreset;
  logic       signal_ok_i;
  logic       valid_i;
  logic [1:0] head_i;
  logic       slip_o;
  logic       block_lock_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ok;
    logic       valid;
    logic [1:0] head;
    logic       exp_slip;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[$];

  pcs_10g_block_sync #(
    .HEAD_W     (2),
    .SH_GOOD_N  (64),
    .SH_BAD_N   (16),
    .SLIP_WAIT_N(2)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .signal_ok_i (signal_ok_i),
    .valid_i     (valid_i),
    .head_i      (head_i),
    .slip_o      (slip_o),
    .block_lock_o(block_lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] good_head();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic void push(logic ok, logic valid, logic [1:0] head, logic es, logic el);
    vec_t v;
    v.ok = ok; v.valid = valid; v.head = head; v.exp_slip = es; v.exp_lock = el;
    vecs.push_back(v);
  endfunction

  // 64 good headers from TEST_SH; lock appears only after the last one.
  // Gap cycles carry an invalid header that must be ignored because valid_i=0.
  function automatic void acquire(int max_gap);
    for (int i = 0; i < 64; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(1, max_gap);
        for (int k = 0; k < g; k++) push(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      end
      push(1'b1, 1'b1, good_head(), 1'b0, (i == 63));
    end
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic run_table(string name);
    int n;
    n = vecs.size();
    for (int i = 0; i < n; i++) begin
      signal_ok_i = vecs[i].ok;
      valid_i     = vecs[i].valid;
      head_i      = vecs[i].head;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].slip", name, i), slip_o, vecs[i].exp_slip);
      check($sformatf("%s[%0d].lock", name, i), block_lock_o, vecs[i].exp_lock);
    end
    vecs.delete();
    $display("%s: %0d vectors applied", name, n);
  endtask

  task automatic pulse_reset(string name);
    nreset = 1'b0;
    #1;
    check({name, ".slip_async"}, slip_o, 1'b0);
    check({name, ".lock_async"}, block_lock_o, 1'b0);
    @(posedge clk);
    #1;
    check({name, ".slip_held"}, slip_o, 1'b0);
    check({name, ".lock_held"}, block_lock_o, 1'b0);
    nreset = 1'b1;
    $display("%s: reset pulse applied", name);
  endtask

  initial begin
    nreset      = 1'b0;
    signal_ok_i = 1'b0;
    valid_i     = 1'b0;
    head_i      = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset.slip", slip_o, 1'b0);
    check("reset.lock", block_lock_o, 1'b0);
    nreset = 1'b1;

    // Clean acquisition: one LOCK_INIT exit cycle, then 64 random good headers
    push(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    acquire(0);
    run_table("acquire");

    // Two locked windows with 15 invalid headers each: the second only holds if counters cleared
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 64; i++)
        push(1'b1, 1'b1, (i < 15) ? ((i % 2) ? 2'b00 : 2'b11) : good_head(), 1'b0, 1'b1);
    run_table("locked_15_bad");

    // 16th invalid lands on the 64th header: loss of lock wins over window end
    for (int i = 0; i < 64; i++)
      push(1'b1, 1'b1, (i >= 48) ? 2'b11 : good_head(), (i == 63), (i != 63));
    // Both headers in SLIP_WAIT are discarded, including an invalid one
    push(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    run_table("locked_16_bad");

    // Invalid header after 10 good ones -> single slip, two discarded, then gapped acquisition
    for (int i = 0; i < 10; i++) push(1'b1, 1'b1, good_head(), 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    push(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    acquire(5);
    run_table("slip_and_gaps");

    // signal_ok drop while locked: no slip even on an invalid header, then full reacquisition
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, good_head(), 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    acquire(0);
    run_table("signal_drop");

    // Reset while locked must clear block_lock_o without waiting for a clock edge
    pulse_reset("reset_locked");

    // Reset at header 40 of acquisition, then a full 64 headers are needed
    push(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) push(1'b1, 1'b1, good_head(), 1'b0, 1'b0);
    run_table("pre_reset_40");
    pulse_reset("reset_mid_acq");
    push(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    acquire(0);
    run_table("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pcs_10g_block_sync

// File: doc/pcs_10g_block_sync.md
PCS_10G_BLOCK_SYNC -- requirements
Module: pcs_10g_block_sync

Interface
REQ-001 Parameters SHALL be: HEAD_W, 2, sync header width; SH_GOOD_N, 64, headers per test window; SH_BAD_N, 16, invalid headers in one window that drop lock; SLIP_WAIT_N, 2, valid cycles ignored after a slip.
REQ-002 clk  input  1  rx parallel clock; the only clock; all logic SHALL be clocked on its rising edge.
REQ-003 nreset  input  1  reset, asynchronous and active-low.
REQ-004 signal_ok_i  input  1  PMA/CDR locked; low forces loss of lock.
REQ-005 valid_i  input  1  head_i carries a new 66b block header this cycle (gearbox output).
REQ-006 head_i  input  HEAD_W  sync header of the current block.
REQ-007 slip_o  output  1  one-cycle pulse; the upstream gearbox shifts block alignment by one bit.
REQ-008 block_lock_o  output  1  block alignment acquired (IEEE 802.3 Cl.49 block_lock).

Function
REQ-009 A header SHALL be valid iff head_i is 2'b01 (data) or 2'b10 (ctrl); 2'b00 and 2'b11 SHALL be invalid.
REQ-010 The FSM SHALL have states LOCK_INIT, TEST_SH, SLIP_WAIT and LOCKED, encoded as an enum.
REQ-011 Counters: sh_cnt 0..SH_GOOD_N and sh_invld_cnt 0..SH_BAD_N, each sized with $clog2(max+1) bits; neither SHALL wrap.
REQ-012 Counters SHALL advance only on cycles where valid_i=1 in TEST_SH or LOCKED; cycles with valid_i=0 SHALL hold all state.
REQ-013 In LOCK_INIT, the FSM SHALL clear both counters and go to TEST_SH on the next cycle with signal_ok_i=1.
REQ-014 In TEST_SH, on an invalid header the FSM SHALL drive slip_o=1 the next cycle, clear the counters and enter SLIP_WAIT.
REQ-015 In TEST_SH, on the SH_GOOD_N-th consecutive valid header the FSM SHALL enter LOCKED, with block_lock_o=1 on the following cycle, and clear the counters.
REQ-016 SLIP_WAIT SHALL discard SLIP_WAIT_N valid_i cycles, then return to TEST_SH.
REQ-017 In LOCKED, each header SHALL increment sh_cnt, and each invalid header SHALL also increment sh_invld_cnt.
REQ-018 In LOCKED, when sh_invld_cnt reaches SH_BAD_N, the FSM SHALL drop lock: block_lock_o=0 and slip_o=1 the next cycle, then SLIP_WAIT.
REQ-019 In LOCKED, when sh_cnt reaches SH_GOOD_N with sh_invld_cnt<SH_BAD_N, both counters SHALL clear and lock SHALL be held.
REQ-020 If the SH_GOOD_N-th header is also the SH_BAD_N-th invalid header, loss of lock SHALL win.
REQ-021 signal_ok_i=0 in any state SHALL force LOCK_INIT the next cycle, with block_lock_o=0 and slip_o=0; this SHALL take priority over all other transitions.
REQ-022 slip_o SHALL never be high on two consecutive cycles.
REQ-023 Both outputs SHALL be registered; no combinational path SHALL exist from an input to an output.

Reset
REQ-024 While nreset=0, the FSM SHALL be in LOCK_INIT, both counters 0, slip_o=0 and block_lock_o=0.
REQ-025 Reset asserted mid-window or mid-slip SHALL abort immediately; the first header after release SHALL be ignored until LOCK_INIT exits.
REQ-026 Reset deassertion SHALL be synchronised externally; this block SHALL not contain a synchroniser.

Structure
REQ-027 The SYNC_DATA/SYNC_CTRL constants and the FSM state enum SHALL live in the shared pcs_10g package, reused by the loopback and decoder.
REQ-028 The block SHALL be a single module with no sub-modules; counters and FSM SHALL be inline.
REQ-029 The block SHALL sit between the rx gearbox (slip_o, valid_i/head_i) and pcs_10g_loopback (block_lock_o drives rx_locked_i).

Verification
REQ-030 Apply signal_ok_i=1 and 64 valid headers with random 01/10 -> block_lock_o=1 exactly one cycle after the 64th header; slip_o never asserted.
REQ-031 Apply 10 valid headers, then head_i=2'b11 -> slip_o pulses for 1 cycle; the next 2 valid cycles are ignored; a further 64 valid headers give lock.
REQ-032 While locked, inject 15 invalid headers in one 64-header window -> lock held, counters clear at the window end; inject 16 -> block_lock_o=0 and one slip_o pulse.
REQ-033 Apply valid_i=0 gaps of 1-5 cycles between headers during acquisition -> lock after exactly 64 valid headers; gaps do not change the lock timing.
REQ-034 While locked, drop signal_ok_i for 1 cycle -> block_lock_o=0 the next cycle, no slip; reacquisition takes 64 valid headers.
REQ-035 Assert nreset at header 40 of acquisition -> all outputs 0 immediately; after release, lock requires a full 64 headers.
